// File: rtl/deserial_frame_if.sv
// Output-side bundle of the frame deserialiser: held payload, its length,
// the valid/ready handshake and the one-cycle error report.
interface deserial_frame_if #(
    parameter int MAX_W = 32,
    parameter int LEN_W = 6
);
    logic [MAX_W-1:0] dat_o;
    logic [LEN_W-1:0] length_o;
    logic             valid_o;
    logic             ready_i;
    logic             err_o;
    logic [1:0]       err_code_o;

    modport master (
        output dat_o, length_o, valid_o, err_o, err_code_o,
        input  ready_i
    );

    modport slave (
        input  dat_o, length_o, valid_o, err_o, err_code_o,
        output ready_i
    );
endinterface

// File: rtl/deserial_frame.sv
// Delimited serial frame receiver: oversamples an asynchronous clock/data pair,
// strips SOF/EOF and hands the right-aligned payload out over valid/ready.
module deserial_frame #(
    parameter int                MAX_W     = 32,
    parameter int                LEN_W     = 6,
    parameter int                SOF_W     = 4,
    parameter logic [SOF_W-1:0]  SOF       = 4'b1010,
    parameter int                EOF_W     = 4,
    parameter logic [EOF_W-1:0]  EOF       = 4'b0111,
    parameter bit                MSB_FIRST = 1'b1,
    parameter int                TIMEOUT   = 1024
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          serial_clk,
    input  logic          serial_i,
    deserial_frame_if.master out_if
);
    localparam int SHW   = MAX_W + EOF_W;
    localparam int CNT_W = $clog2(SHW + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] EOF_CNT  = CNT_W'(EOF_W);
    localparam logic [CNT_W-1:0] SHW_CNT  = CNT_W'(SHW);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_W);

    typedef enum logic {HUNT, RECV} state_t;

    typedef enum logic [1:0] {
        ERR_EMPTY   = 2'b00,
        ERR_OVF     = 2'b01,
        ERR_TMO     = 2'b10,
        ERR_OVERRUN = 2'b11
    } err_t;

    state_t           state_q, state_d;
    logic [1:0]       csync_q, dsync_q;
    logic             cprev_q;
    logic [SHW-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             valid_q, valid_d;
    logic [MAX_W-1:0] dat_q, dat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             err_q, err_d;
    err_t             err_code_q, err_code_d;

    logic             s_evt, s_bit;
    logic             frm_done, frm_empty, frm_ovf, frm_tmo;
    logic [LEN_W-1:0] frm_len;
    logic [MAX_W-1:0] raw_pl, rev_pl, payload;

    // A sample event is the first cycle the synchronised serial clock reads high.
    assign s_evt = csync_q[1] & ~cprev_q;
    assign s_bit = dsync_q[1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= HUNT;
            csync_q    <= '0;
            dsync_q    <= '0;
            cprev_q    <= 1'b0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            valid_q    <= 1'b0;
            dat_q      <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_EMPTY;
        end else begin
            state_q    <= state_d;
            csync_q    <= {csync_q[0], serial_clk};
            dsync_q    <= {dsync_q[0], serial_i};
            cprev_q    <= csync_q[1];
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            valid_q    <= valid_d;
            dat_q      <= dat_d;
            len_q      <= len_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        shreg_d   = shreg_q;
        frm_done  = 1'b0;
        frm_empty = 1'b0;
        frm_ovf   = 1'b0;
        frm_tmo   = 1'b0;

        if (s_evt) begin
            shreg_d = {shreg_q[SHW-2:0], s_bit};
        end

        case (state_q)
            HUNT: begin
                cnt_d = '0;
                tmo_d = '0;
                if (s_evt && shreg_d[SOF_W-1:0] == SOF) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (s_evt) begin
                    cnt_d = cnt_q + 1'b1;
                    tmo_d = '0;
                    // EOF wins over overflow when both land on the same bit.
                    if (cnt_d >= EOF_CNT && shreg_d[EOF_W-1:0] == EOF) begin
                        state_d   = HUNT;
                        frm_empty = (cnt_d == EOF_CNT);
                        frm_done  = (cnt_d != EOF_CNT);
                    end else if (cnt_d == SHW_CNT) begin
                        state_d = HUNT;
                        frm_ovf = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = HUNT;
                    tmo_d   = '0;
                    frm_tmo = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Payload extraction: mask above the length, or mirror within the length.
    always_comb begin
        frm_len = LEN_W'(cnt_d - EOF_CNT);
        raw_pl  = shreg_d[EOF_W +: MAX_W];
        for (int i = 0; i < MAX_W; i++) begin
            rev_pl[i] = raw_pl[MAX_W-1-i];
        end
        if (MSB_FIRST) begin
            payload = raw_pl & ~({MAX_W{1'b1}} << frm_len);
        end else begin
            payload = rev_pl >> (MAX_LEN - frm_len);
        end
    end

    always_comb begin
        valid_d    = valid_q;
        dat_d      = dat_q;
        len_d      = len_q;
        err_d      = 1'b0;
        err_code_d = ERR_EMPTY;

        if (valid_q && out_if.ready_i) begin
            valid_d = 1'b0;
        end

        if (frm_done) begin
            if (valid_q && !out_if.ready_i) begin
                err_d      = 1'b1;
                err_code_d = ERR_OVERRUN;
            end else begin
                valid_d = 1'b1;
                dat_d   = payload;
                len_d   = frm_len;
            end
        end else if (frm_empty) begin
            err_d      = 1'b1;
            err_code_d = ERR_EMPTY;
        end else if (frm_ovf) begin
            err_d      = 1'b1;
            err_code_d = ERR_OVF;
        end else if (frm_tmo) begin
            err_d      = 1'b1;
            err_code_d = ERR_TMO;
        end
    end

    assign out_if.dat_o      = dat_q;
    assign out_if.length_o   = len_q;
    assign out_if.valid_o    = valid_q;
    assign out_if.err_o      = err_q;
    assign out_if.err_code_o = err_code_q;
endmodule

// File: tb/tb_deserial_frame.sv
// Bench for deserial_frame: two instances (MSB-first and LSB-first) share the
// serial line; a frame-level model predicts payloads and error codes.
module tb_deserial_frame;
    localparam int         MAX_W   = 32;
    localparam int         LEN_W   = 6;
    localparam int         SOF_W   = 4;
    localparam int         EOF_W   = 4;
    localparam int         TIMEOUT = 16;
    localparam logic [3:0] SOF_P   = 4'b1010;
    localparam logic [3:0] EOF_P   = 4'b0111;

    typedef logic [LEN_W+MAX_W-1:0] frm_t;

    logic clk_i      = 1'b0;
    logic rst_i      = 1'b1;
    logic serial_clk = 1'b0;
    logic serial_i   = 1'b1;
    logic rdy_a      = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    deserial_frame_if #(.MAX_W(MAX_W), .LEN_W(LEN_W)) if_a ();
    deserial_frame_if #(.MAX_W(MAX_W), .LEN_W(LEN_W)) if_b ();

    assign if_a.ready_i = rdy_a;
    assign if_b.ready_i = 1'b1;

    deserial_frame #(
        .MAX_W(MAX_W), .LEN_W(LEN_W), .SOF_W(SOF_W), .SOF(SOF_P),
        .EOF_W(EOF_W), .EOF(EOF_P), .MSB_FIRST(1'b1), .TIMEOUT(TIMEOUT)
    ) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .serial_clk(serial_clk),
        .serial_i(serial_i), .out_if(if_a)
    );

    deserial_frame #(
        .MAX_W(MAX_W), .LEN_W(LEN_W), .SOF_W(SOF_W), .SOF(SOF_P),
        .EOF_W(EOF_W), .EOF(EOF_P), .MSB_FIRST(1'b0), .TIMEOUT(TIMEOUT)
    ) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .serial_clk(serial_clk),
        .serial_i(serial_i), .out_if(if_b)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Observed events
    frm_t got_err_a[$], got_err_b[$], got_frm_a[$], got_frm_b[$];
    // Predicted events
    frm_t exp_err_a[$], exp_err_b[$], exp_frm_a[$], exp_frm_b[$];

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (if_a.err_o) got_err_a.push_back(frm_t'(if_a.err_code_o));
            if (if_b.err_o) got_err_b.push_back(frm_t'(if_b.err_code_o));
            if (if_a.valid_o && if_a.ready_i) got_frm_a.push_back({if_a.length_o, if_a.dat_o});
            if (if_b.valid_o && if_b.ready_i) got_frm_b.push_back({if_b.length_o, if_b.dat_o});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    bit m_recv;
    bit m_held;
    bit recent[$];
    bit fq[$];

    function automatic int tail_val(input bit q[$], input int w);
        int v = 0;
        for (int i = q.size() - w; i < q.size(); i++) v = v * 2 + int'(q[i]);
        return v;
    endfunction

    task automatic model_frame(input int len);
        logic [MAX_W-1:0] va = '0;
        logic [MAX_W-1:0] vb = '0;
        for (int i = 0; i < len; i++) begin
            va    = (va << 1) | MAX_W'(fq[i]);
            vb[i] = fq[i];
        end
        if (len == 0) begin
            exp_err_a.push_back(frm_t'(0));
            exp_err_b.push_back(frm_t'(0));
        end else begin
            exp_frm_b.push_back({LEN_W'(len), vb});
            if (m_held && !rdy_a) begin
                exp_err_a.push_back(frm_t'(3));
            end else begin
                exp_frm_a.push_back({LEN_W'(len), va});
                m_held = !rdy_a;
            end
        end
    endtask

    task automatic model_bit(input bit b);
        recent.push_back(b);
        if (recent.size() > SOF_W) void'(recent.pop_front());
        if (!m_recv) begin
            if (tail_val(recent, SOF_W) == int'(SOF_P)) begin
                m_recv = 1'b1;
                fq.delete();
            end
        end else begin
            fq.push_back(b);
            if (fq.size() >= EOF_W && tail_val(fq, EOF_W) == int'(EOF_P)) begin
                m_recv = 1'b0;
                model_frame(fq.size() - EOF_W);
            end else if (fq.size() == MAX_W + EOF_W) begin
                m_recv = 1'b0;
                exp_err_a.push_back(frm_t'(1));
                exp_err_b.push_back(frm_t'(1));
            end
        end
    endtask

    task automatic model_reset();
        if (m_held) void'(exp_frm_a.pop_back());
        m_held = 1'b0;
        m_recv = 1'b0;
        recent.delete();
        for (int i = 0; i < SOF_W; i++) recent.push_back(1'b0);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drv_wait(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic set_ready(input bit r);
        rdy_a = r;
        if (r) m_held = 1'b0;
    endtask

    task automatic send_bit(input bit b, output int lat);
        lat      = 0;
        serial_i = b;
        drv_wait(5);
        serial_clk = 1'b1;
        model_bit(b);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk_i);
            #1;
            if (lat == 0 && if_a.valid_o) lat = k;
        end
        serial_clk = 1'b0;
    endtask

    task automatic send_frame(input string s, output int lat);
        lat = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "0" || s[i] == "1") send_bit(s[i] == "1", lat);
        end
    endtask

    task automatic idle(input int n);
        drv_wait(n);
        if (m_recv && n >= TIMEOUT) begin
            m_recv = 1'b0;
            exp_err_a.push_back(frm_t'(2));
            exp_err_b.push_back(frm_t'(2));
        end
    endtask

    task automatic cmp_q(input string tag, input frm_t got[$], input frm_t exp[$]);
        check({tag, " count"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            check({tag, " item"}, 64'(got[i]), 64'(exp[i]));
        end
    endtask

    task automatic checkpoint(input string tag);
        drv_wait(4);
        cmp_q({tag, " err_a"}, got_err_a, exp_err_a);
        cmp_q({tag, " err_b"}, got_err_b, exp_err_b);
        cmp_q({tag, " frm_a"}, got_frm_a, exp_frm_a);
        cmp_q({tag, " frm_b"}, got_frm_b, exp_frm_b);
        got_err_a.delete(); got_err_b.delete(); got_frm_a.delete(); got_frm_b.delete();
        exp_err_a.delete(); exp_err_b.delete(); exp_frm_a.delete(); exp_frm_b.delete();
    endtask

    function automatic string zeros(input int n);
        string s = "";
        for (int i = 0; i < n; i++) s = {s, "0"};
        return s;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int    lat;
        bit    stable;
        frm_t  held;
        string s;

        model_reset();
        drv_wait(3);
        check("reset valid", if_a.valid_o, 0);
        check("reset dat", if_a.dat_o, 0);
        check("reset len", if_a.length_o, 0);
        check("reset err", {if_a.err_o, if_a.err_code_o}, 0);
        rst_i = 1'b0;
        drv_wait(3);

        // 1: basic frame, output latency
        send_frame("1010 11001 0111", lat);
        check("t1 valid latency", lat, 3);
        check("t1 dat_b", if_b.dat_o, 32'h13);
        checkpoint("t1");

        // 2: held under back-pressure
        set_ready(1'b0);
        send_frame("1010 1101 0111", lat);
        held = exp_frm_a[exp_frm_a.size()-1];
        check("t2 held frame", {if_a.length_o, if_a.dat_o}, held);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drv_wait(1);
            if ({if_a.length_o, if_a.dat_o} !== held || !if_a.valid_o) stable = 1'b0;
        end
        check("t2 stable", stable, 1);

        // 3: overrun while still held
        send_frame("1010 11001 0111", lat);
        check("t3 dat kept", {if_a.length_o, if_a.dat_o}, held);
        set_ready(1'b1);
        drv_wait(1);
        check("t3 valid drop", if_a.valid_o, 0);
        checkpoint("t3");

        // 4: overflow, then a 1-bit frame, then a full MAX_W frame
        send_frame({"1010", zeros(36)}, lat);
        send_frame("1010 1 0111", lat);
        send_frame("1010 10100101101001011010010110100101 0111", lat);
        checkpoint("t4");

        // 5: timeout, then empty payload
        send_frame("1010 101", lat);
        idle(40);
        send_frame("1010 0111", lat);
        check("t5 no valid", if_a.valid_o, 0);
        checkpoint("t5");

        // 6: reset mid-frame with a held output
        set_ready(1'b0);
        send_frame("1010 1 0111", lat);
        send_frame("1010 11", lat);
        rst_i = 1'b1;
        #1;
        check("t6 reset valid", if_a.valid_o, 0);
        check("t6 reset dat", if_a.dat_o, 0);
        check("t6 reset len", if_a.length_o, 0);
        model_reset();
        set_ready(1'b1);
        drv_wait(2);
        rst_i = 1'b0;
        drv_wait(2);
        send_frame("1010 11001 0111", lat);
        checkpoint("t6");

        // Randomised frames mixing errors and back-pressure
        for (int f = 0; f < 24; f++) begin
            int mode;
            int len;
            int h;
            bit b;
            mode = int'($urandom_range(0, 9));
            set_ready(bit'($urandom_range(0, 1)));
            s = "1010";
            h = 0;
            if (mode == 0)      len = 0;
            else if (mode == 1) len = int'($urandom_range(0, 6));
            else if (mode == 2) len = MAX_W + EOF_W;
            else                len = int'($urandom_range(1, MAX_W));
            for (int i = 0; i < len; i++) begin
                b = bit'($urandom_range(0, 1));
                if (b && (h & 7) == 3) b = 1'b0;
                h = (h << 1) | int'(b);
                if (b) s = {s, "1"};
                else   s = {s, "0"};
            end
            if (mode == 1) begin
                send_frame(s, lat);
                idle(40);
            end else if (mode == 2) begin
                send_frame(s, lat);
            end else begin
                send_frame({s, "0111"}, lat);
            end
            if (f % 4 == 3) begin
                set_ready(1'b1);
                checkpoint("rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/deserial_frame.md
Name: deserial_frame

Overview:
Parametrised successor to the fixed 32-bit frame deserialiser. It receives a delimited serial frame on an asynchronous serial clock/data pair: idle-high line, SOF pattern, variable-length payload, EOF pattern. It oversamples the pair in the system clock domain and strips the delimiters. It returns the right-aligned payload and its bit length over a valid/ready handshake. Added over the previous block: configurable delimiters and bit order, output back-pressure, line timeout, and error reporting.

Parameters:
MAX_W, 32, maximum payload bits per frame
LEN_W, 6, width of length_o; must be at least clog2(MAX_W+1)
SOF_W, 4, start-delimiter width
SOF, 4'b1010, start-delimiter pattern, first-received bit in MSB
EOF_W, 4, end-delimiter width
EOF, 4'b0111, end-delimiter pattern, first-received bit in MSB
MSB_FIRST, 1, 1: first payload bit lands in dat_o[length_o-1]; 0: first payload bit lands in dat_o[0]
TIMEOUT, 1024, clk_i cycles without a serial_clk rising edge before a frame in progress is aborted

Ports:
clk_i  in  1  system clock; the only clock in the block
rst_i  in  1  asynchronous, active-high reset
serial_clk  in  1  asynchronous serial bit clock; data is sampled on its rising edge
serial_i  in  1  asynchronous serial data; idle level 1
dat_o  out  MAX_W  payload, right-aligned, zero above length_o
length_o  out  LEN_W  payload bit count, 1..MAX_W
valid_o  out  1  dat_o/length_o hold a frame
ready_i  in  1  consumer accepts the frame when valid_o&&ready_i
err_o  out  1  one-cycle error pulse
err_code_o  out  2  valid with err_o: 00 empty payload, 01 overflow, 10 timeout, 11 output overrun

Behaviour:
- Reset (async assert, release synchronous to clk_i): state=HUNT; all outputs 0; shift register, bit counter and timeout counter cleared. Reset mid-frame discards the frame and any held output.
- Input sync: serial_clk and serial_i each pass through 2-FF synchronisers of equal depth. A sample event S occurs in the cycle a 0->1 transition is seen on the synchronised clock; the bit taken is the synchronised serial_i in that cycle.
- Input constraints: serial_clk high and low phases are each >=3 clk_i periods. serial_i is stable for >=3 clk_i periods around the rising edge.
- Shift register: SHW = MAX_W+EOF_W bits. Every S shifts the new bit into bit 0.
- HUNT: on S, compare the last SOF_W received bits with SOF. On a match, go to RECV with cnt=0. A partial SOF is never carried into RECV.
- RECV: on S, cnt++. When cnt>=EOF_W and the last EOF_W bits equal EOF, the frame ends: payload length = cnt-EOF_W.
  - length 0: err_o with code 00, frame dropped.
  - length >0: frame goes to the output stage.
  - In every case, next state is HUNT.
- Payload must not contain the EOF pattern. Bit stuffing is out of scope; the first EOF match always terminates the frame.
- Overflow: an S that makes cnt=MAX_W+EOF_W with no EOF match gives err_o with code 01. Frame dropped, go to HUNT.
- Timeout: in RECV, a counter counts clk_i cycles since the last S. When it reaches TIMEOUT: err_o with code 10, go to HUNT. The counter is held at 0 in HUNT.
- Output stage: a single holding register.
  - valid_o rises in the cycle after EOF detection (S+1).
  - dat_o/length_o stay stable while valid_o && !ready_i.
  - valid_o falls the cycle after a handshake.
  - If a frame completes with valid_o=1 and ready_i=0 in that cycle: new frame dropped, held frame kept, err_o with code 11.
  - If ready_i=1 in that same cycle, the new frame replaces the old one with no gap and no error.
- Bit order: MSB_FIRST=1 means payload = shreg[EOF_W +: length]. MSB_FIRST=0 bit-reverses the payload within length. Bits at and above length are 0 in both modes.
- Simultaneous events: EOF match and overflow on the same S resolve as EOF (a valid frame of MAX_W bits). A timeout cannot coincide with S; S resets the counter first.

Test Plan:
1. Reset, idle high, serial half-period 5 clk; send 1010 11001 0111 -> valid_o at S+1 of the last bit, dat_o=0x19, length_o=5, err_o never pulses.
2. Send 1010 1101 0111 with ready_i=0 for 20 cycles -> dat_o=0xD, length_o=4 held stable; one cycle after ready_i=1, valid_o=0.
3. While frame 2 is still held with ready_i=0, send 1010 11001 0111 -> err_o with code 11; dat_o stays 0xD.
4. SOF followed by 36 zero bits -> err_o with code 01 on the 36th S; next frame 1010 1 0111 returns dat_o=1, length_o=1.
5. SOF, 3 bits, then serial_clk stopped for TIMEOUT=16 -> err_o with code 10 at cycle 16; 1010 0111 -> err_o with code 00 and no valid_o.
6. MSB_FIRST=0; send 1010 11001 0111 -> dat_o=0x13, length_o=5. Assert rst_i mid-frame -> all outputs 0 immediately; next full frame is received correctly.
